flatten_forward: RTL and testbench
==================================

# flatten_forward

FPU-side tensor op that flattens an N-dimensional tensor into a 1-D tensor. It reads the source tensor through memory handle `a` (header, then data) and writes the flattened tensor through handle `d`. It is dispatched by the FPU controller with the same `go`/`done` handshake as the other tensor ops. It is the forward counterpart of the flatten-backward op: that op restores shape, this op collapses it.

## Interface
- `MAX_DIMS`, default 4: maximum legal `ndims` when the check feature is compiled in.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `a`  mem_handle  —  source tensor. Read only; `a.w_en` is held 0.
- `b`, `c`  mem_handle  —  unused. All driven fields are held 0.
- `d`  mem_handle  —  destination tensor. Write only; `d.r_en` is held 0.
- `go`  in  1  start request; level-held by the controller.
- `done`  out  1  op complete; held until `go` drops.
- `err`  out  1  bad header detected. Tied 0 unless `FLATTEN_FW_CHECK_EN` is defined.

## Operation
- Tensor layout:
  - word 0 = `ndims`.
  - words 1..`ndims` = dims.
  - data follows.
  - Output layout: word 0 = 1, word 1 = `len` (product of dims), data at word 2.
- Memory transaction rule:
  - The block asserts `avail` plus `r_en` or `w_en`. For writes, `data_store` is set in the same cycle.
  - These are held until `done` is sampled high.
  - In that cycle the block deasserts them (registered, so low next cycle) and increments `ptr`.
  - On a read, `data_load` is captured in that same cycle.
- FSM states:
  - **WAIT**: go to RD_N when `go`=1.
  - **RD_N**: on entry, `a.ptr`=`a.region_begin` and `d.ptr`=`d.region_begin`. Read `ndims`, set `len`=1, set dim counter `k`=0. On `a.done`, go to RD_DIM.
  - **RD_DIM**: if `k`==`ndims`, go to W_HDR0. Otherwise read one dim; on `a.done`, `len` <= `len`*dim (32-bit, modulo 2^32) and `k`++.
  - **W_HDR0**: write 1. On `d.done`, go to W_HDR1.
  - **W_HDR1**: write `len`. On `d.done`, go to LOOP with element counter `i`=0.
  - **LOOP**: if `i`==`len`, go to DONE. Otherwise go to LOOP_R.
  - **LOOP_R**: read the element into the hold register. On `a.done`, go to LOOP_W.
  - **LOOP_W**: write the hold register with `avail`=1. On `d.done`, `i`++ and go to LOOP.
  - **DONE**: `done`=1. Go to WAIT when `go`=0.
- Boundary behaviour:
  - `ndims`=0 gives `len`=1: the scalar is copied and the header is written as 1,1.
  - Any dim = 0 gives `len`=0: both header words are written and no data is copied.
  - `go` dropping mid-op is ignored; the op runs to DONE.
  - `go` still high in DONE does not restart the op.

## Timing
- Reset (sync, `rst`=1 at the edge):
  - state = WAIT; `done`=0; `err`=0.
  - All handle `w_en`/`r_en`/`avail`/`ptr`/`data_store` = 0.
  - Reset mid-transaction drops the request on the following edge. No further writes to `d` occur.
- `done` rises 1 cycle after the final LOOP evaluation. It falls 1 cycle after `go`=0 is sampled.
- Requests appear 1 cycle after state entry and are never asserted back-to-back: there is at least 1 idle cycle between transactions.
- Cycle count, with memory `done` L cycles after a request is visible:
  - Per transaction: L+2.
  - Per element: 2(L+2)+1.
  - Total: 2 + (1+`ndims`)(L+2) + 1 + 2(L+2) + `len`(2L+5) + 1.
- `a` and `d` requests are never asserted in the same cycle.

## Configuration
- `FLATTEN_FW_CHECK_EN` defined:
  - After RD_N, `ndims` > `MAX_DIMS` goes to DONE with `err`=1, and no dims are read.
  - In RD_DIM, a 64-bit product with a nonzero upper half goes to DONE with `err`=1.
  - In both cases nothing is ever written to `d`.
  - `err` clears on the DONE→WAIT transition or on reset.
- Not defined:
  - `err` is tied 0 and `MAX_DIMS` is ignored.
  - Any `ndims` is accepted, and the `len` product wraps modulo 2^32.

## Test plan
- Source 3,2,3,4 then data 0..23, L=1 -> `d` = 1, 24, 0..23. `done` rises after the 24th write. `a.ptr` ends at `region_begin`+28.
- Source 1,5 with 5 words -> `d` = 1, 5, same 5 words. This is a pass-through shape.
- Source 2,3,0 -> `d` = 1, 0. Zero data reads; `done` asserted.
- Memory with random L in 1..4 and `go` dropped mid-copy -> `d` contents identical to the L=1 run. `done` follows the DONE rules; no back-to-back requests.
- `rst`=1 during the 10th element write -> all requests and `done` are 0 next cycle, state is WAIT, and a fresh `go` recopies correctly.
- With `FLATTEN_FW_CHECK_EN`:
  - `ndims`=5 -> `err`=1, `d` untouched.
  - Dims 65536,65536 -> `err`=1 after the 2nd dim read.

Source files
------------

// File: rtl/flatten_forward_if.sv
// Memory handle between a tensor op and its memory port: request/ack with held request.
interface flatten_forward_if;
  logic [31:0] region_begin;
  logic [31:0] ptr;
  logic [31:0] data_store;
  logic [31:0] data_load;
  logic        avail;
  logic        r_en;
  logic        w_en;
  logic        done;

  modport master (
    input  region_begin, data_load, done,
    output ptr, data_store, avail, r_en, w_en
  );

  modport slave (
    output region_begin, data_load, done,
    input  ptr, data_store, avail, r_en, w_en
  );
endinterface

// File: rtl/flatten_forward.sv
// Flattens an N-d tensor read through handle a into a 1-D tensor (1, len, data) written through d.
// Optional header checking (ndims limit, 32-bit len overflow) is compiled in with FLATTEN_FW_CHECK_EN.
module flatten_forward #(
  parameter int MAX_DIMS = 4
) (
  input  logic               clk,
  input  logic               rst,
  flatten_forward_if.master  a,
  flatten_forward_if.master  b,
  flatten_forward_if.master  c,
  flatten_forward_if.master  d,
  input  logic               go,
  output logic               done,
  output logic               err
);

  typedef enum logic [3:0] {
    S_WAIT, S_RD_N, S_RD_DIM, S_W_HDR0, S_W_HDR1, S_LOOP, S_LOOP_R, S_LOOP_W, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_ptr_q, a_ptr_d, d_ptr_q, d_ptr_d;
  logic        a_req_q, a_req_d, d_req_q, d_req_d;
  logic [31:0] d_dat_q, d_dat_d;
  logic [31:0] ndims_q, ndims_d, len_q, len_d, k_q, k_d, i_q, i_d, hold_q, hold_d;
  logic        a_ack, d_ack, a_rd, d_wr, ndims_bad, len_ovf;
  logic [31:0] wr_val, len_next;

  assign a_ack = a_req_q & a.done;
  assign d_ack = d_req_q & d.done;
  assign a_rd  = (state_q == S_RD_N) || (state_q == S_LOOP_R) ||
                 (state_q == S_RD_DIM && k_q != ndims_q);
  assign d_wr  = (state_q == S_W_HDR0) || (state_q == S_W_HDR1) || (state_q == S_LOOP_W);
  assign wr_val = (state_q == S_W_HDR0) ? 32'd1 : (state_q == S_W_HDR1) ? len_q : hold_q;

`ifdef FLATTEN_FW_CHECK_EN
  logic [31:0] len_hi;
  logic        err_q, err_d;

  assign {len_hi, len_next} = {32'd0, len_q} * {32'd0, a.data_load};
  assign len_ovf   = |len_hi;
  assign ndims_bad = a.data_load > MAX_DIMS;

  always_comb begin
    err_d = err_q;
    if ((state_q == S_RD_N && a_ack && ndims_bad) || (state_q == S_RD_DIM && a_ack && len_ovf))
      err_d = 1'b1;
    else if (state_q == S_DONE && !go)
      err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  localparam int unused_max_dims = MAX_DIMS;
  assign len_next  = len_q * a.data_load;
  assign len_ovf   = 1'b0;
  assign ndims_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      a_ptr_q <= '0;
      d_ptr_q <= '0;
      a_req_q <= 1'b0;
      d_req_q <= 1'b0;
      d_dat_q <= '0;
      ndims_q <= '0;
      len_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      a_ptr_q <= a_ptr_d;
      d_ptr_q <= d_ptr_d;
      a_req_q <= a_req_d;
      d_req_q <= d_req_d;
      d_dat_q <= d_dat_d;
      ndims_q <= ndims_d;
      len_q   <= len_d;
      k_q     <= k_d;
      i_q     <= i_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (go) state_d = S_RD_N;
      S_RD_N:   if (a_ack) state_d = ndims_bad ? S_DONE : S_RD_DIM;
      S_RD_DIM: begin
        if (!a_req_q && k_q == ndims_q) state_d = S_W_HDR0;
        else if (a_ack && len_ovf)      state_d = S_DONE;
      end
      S_W_HDR0: if (d_ack) state_d = S_W_HDR1;
      S_W_HDR1: if (d_ack) state_d = S_LOOP;
      S_LOOP:   state_d = (i_q == len_q) ? S_DONE : S_LOOP_R;
      S_LOOP_R: if (a_ack) state_d = S_LOOP_W;
      S_LOOP_W: if (d_ack) state_d = S_LOOP;
      S_DONE:   if (!go) state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // Requests rise the cycle after a state issues them and drop on the acked edge,
  // which leaves one idle cycle between consecutive transactions.
  always_comb begin
    a_ptr_d = a_ptr_q;
    d_ptr_d = d_ptr_q;
    a_req_d = a_req_q;
    d_req_d = d_req_q;
    d_dat_d = d_dat_q;
    ndims_d = ndims_q;
    len_d   = len_q;
    k_d     = k_q;
    i_d     = i_q;
    hold_d  = hold_q;
    done    = (state_q == S_DONE);

    if (state_q == S_WAIT && go) begin
      a_ptr_d = a.region_begin;
      d_ptr_d = d.region_begin;
    end
    if (a_rd) begin
      if (!a_req_q) begin
        a_req_d = 1'b1;
      end else if (a.done) begin
        a_req_d = 1'b0;
        a_ptr_d = a_ptr_q + 32'd1;
      end
    end
    if (d_wr) begin
      if (!d_req_q) begin
        d_req_d = 1'b1;
        d_dat_d = wr_val;
      end else if (d.done) begin
        d_req_d = 1'b0;
        d_ptr_d = d_ptr_q + 32'd1;
      end
    end
    if (a_ack) begin
      case (state_q)
        S_RD_N: begin
          ndims_d = a.data_load;
          len_d   = 32'd1;
          k_d     = '0;
        end
        S_RD_DIM: begin
          len_d = len_next;
          k_d   = k_q + 32'd1;
        end
        S_LOOP_R: hold_d = a.data_load;
        default: ;
      endcase
    end
    if (d_ack) begin
      case (state_q)
        S_W_HDR1: i_d = '0;
        S_LOOP_W: i_d = i_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign a.ptr        = a_ptr_q;
  assign a.avail      = a_req_q;
  assign a.r_en       = a_req_q;
  assign a.w_en       = 1'b0;
  assign a.data_store = '0;

  assign d.ptr        = d_ptr_q;
  assign d.avail      = d_req_q;
  assign d.r_en       = 1'b0;
  assign d.w_en       = d_req_q;
  assign d.data_store = d_dat_q;

  assign b.ptr = '0;
  assign b.avail = 1'b0;
  assign b.r_en = 1'b0;
  assign b.w_en = 1'b0;
  assign b.data_store = '0;
  assign c.ptr = '0;
  assign c.avail = 1'b0;
  assign c.r_en = 1'b0;
  assign c.w_en = 1'b0;
  assign c.data_store = '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, b.region_begin, b.data_load, b.done,
                       c.region_begin, c.data_load, c.done, d.data_load};

endmodule

// File: tb/tb_flatten_forward.sv
// Bench for flatten_forward: latency-configurable memory model, write scoreboard, vector table.
module tb_flatten_forward;
  localparam int A0 = 16;
  localparam int D0 = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic done, err;

  always #5 clk = ~clk;

  flatten_forward_if a_if ();
  flatten_forward_if b_if ();
  flatten_forward_if c_if ();
  flatten_forward_if d_if ();

  flatten_forward #(.MAX_DIMS(4)) dut (
    .clk(clk), .rst(rst), .a(a_if), .b(b_if), .c(c_if), .d(d_if),
    .go(go), .done(done), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int nd;
    int dims [4];
    bit rnd;
    bit drop;
    int len;
  } vec_t;

  logic [31:0] mem_a [0:255];
  wr_t         wlog  [0:1023];
  wr_t         sb [$];
  int          checks = 0, errors = 0;
  int          rd_count = 0, wr_count = 0, viol = 0;
  int          a_cnt = 0, d_cnt = 0, a_lat = 1, d_lat = 1;
  bit          done_prev = 1'b0;
  bit          rand_lat = 1'b0;

  // Memory model: done rises L cycles after a request is first visible, held until the request drops.
  always @(negedge clk) begin
    if (rst) begin
      a_if.done = 1'b0;
      a_if.data_load = '0;
      d_if.done = 1'b0;
      d_if.data_load = '0;
      a_cnt = 0;
      d_cnt = 0;
      done_prev = 1'b0;
    end else begin
      if ((a_if.avail || d_if.avail) && done_prev) begin
        viol++;
        $display("protocol violation: request in cycle after ack at %0t", $time);
      end
      if (a_if.avail && d_if.avail) begin
        viol++;
        $display("protocol violation: a and d requests together at %0t", $time);
      end
      if (a_if.w_en || d_if.r_en || b_if.avail || b_if.r_en || b_if.w_en || (|b_if.ptr) ||
          (|b_if.data_store) || c_if.avail || c_if.r_en || c_if.w_en || (|c_if.ptr) ||
          (|c_if.data_store)) begin
        viol++;
        $display("protocol violation: held-zero port driven at %0t", $time);
      end
      if (a_if.avail && a_if.r_en) begin
        if (!a_if.done) begin
          if (a_cnt == 0) a_lat = rand_lat ? int'($urandom_range(4, 1)) : 1;
          a_cnt++;
          if (a_cnt > a_lat) begin
            a_if.done = 1'b1;
            a_if.data_load = mem_a[a_if.ptr[7:0]];
            rd_count++;
          end
        end
      end else begin
        a_if.done = 1'b0;
        a_cnt = 0;
      end
      if (d_if.avail && d_if.w_en) begin
        if (!d_if.done) begin
          if (d_cnt == 0) d_lat = rand_lat ? int'($urandom_range(4, 1)) : 1;
          d_cnt++;
          if (d_cnt > d_lat) begin
            d_if.done = 1'b1;
            wlog[wr_count & 1023] = {d_if.ptr, d_if.data_store};
            wr_count++;
          end
        end
      end else begin
        d_if.done = 1'b0;
        d_cnt = 0;
      end
      done_prev = a_if.done | d_if.done;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_vec(input vec_t v, input int vid);
    mem_a[A0] = v.nd;
    for (int j = 0; j < v.nd; j++) mem_a[A0 + 1 + j] = v.dims[j];
    for (int j = 0; j < v.len; j++) mem_a[A0 + 1 + v.nd + j] = vid * 1000 + j;
    sb.delete();
    sb.push_back({32'(D0), 32'd1});
    sb.push_back({32'(D0 + 1), 32'(v.len)});
    for (int j = 0; j < v.len; j++) sb.push_back({32'(D0 + 2 + j), 32'(vid * 1000 + j)});
    rand_lat = v.rnd;
  endtask

  task automatic run_vec(input vec_t v, input int vid, input bit chk_cyc);
    int  wbase, rbase, vbase, cyc;
    wr_t e;
    load_vec(v, vid);
    wbase = wr_count;
    rbase = rd_count;
    vbase = viol;
    @(posedge clk);
    #1 go = 1'b1;
    cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (v.drop && cyc == 30) go = 1'b0;
    end
    chk("done_seen", done, 1);
    if (chk_cyc) chk("cycles", cyc, 2 + (1 + v.nd) * 3 + 1 + 6 + v.len * 7 + 1);
    chk("a_ptr_end", a_if.ptr, A0 + 1 + v.nd + v.len);
    chk("d_ptr_end", d_if.ptr, D0 + 2 + v.len);
    chk("reads", rd_count - rbase, 1 + v.nd + v.len);
    chk("writes", wr_count - wbase, v.len + 2);
    chk("err_clean", err, 0);
    for (int k = wbase; k < wr_count; k++) begin
      if (sb.size() == 0) begin
        chk("extra_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", wlog[k & 1023].addr, e.addr);
        chk("wr_data", wlog[k & 1023].data, e.data);
      end
    end
    chk("missing_writes", sb.size(), 0);
    if (!v.drop) begin
      repeat (3) @(negedge clk);
      chk("done_hold", done, 1);
      chk("no_restart", a_if.avail | d_if.avail, 0);
    end
    go = 1'b0;
    @(negedge clk);
    chk("done_fall", done, 0);
    chk("protocol", viol - vbase, 0);
  endtask

`ifdef FLATTEN_FW_CHECK_EN
  task automatic run_err(input int nd, input int d0, input int d1, input int exp_reads);
    int wbase, rbase, cyc;
    mem_a[A0] = nd;
    mem_a[A0 + 1] = d0;
    mem_a[A0 + 2] = d1;
    rand_lat = 1'b0;
    wbase = wr_count;
    rbase = rd_count;
    @(posedge clk);
    #1 go = 1'b1;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("err_done", done, 1);
    chk("err_set", err, 1);
    chk("err_reads", rd_count - rbase, exp_reads);
    chk("err_no_write", wr_count - wbase, 0);
    go = 1'b0;
    @(negedge clk);
    chk("err_clear", err, 0);
  endtask
`endif

  initial begin
    vec_t vt [5];
    int   cyc;
    vt[0].nd = 3; vt[0].dims = '{2, 3, 4, 0};  vt[0].rnd = 0; vt[0].drop = 0; vt[0].len = 24;
    vt[1].nd = 1; vt[1].dims = '{5, 0, 0, 0};  vt[1].rnd = 0; vt[1].drop = 0; vt[1].len = 5;
    vt[2].nd = 2; vt[2].dims = '{3, 0, 0, 0};  vt[2].rnd = 0; vt[2].drop = 0; vt[2].len = 0;
    vt[3].nd = 0; vt[3].dims = '{0, 0, 0, 0};  vt[3].rnd = 0; vt[3].drop = 0; vt[3].len = 1;
    vt[4].nd = 3; vt[4].dims = '{2, 3, 4, 0};  vt[4].rnd = 1; vt[4].drop = 1; vt[4].len = 24;

    for (int j = 0; j < 256; j++) mem_a[j] = '0;
    a_if.region_begin = A0;
    d_if.region_begin = D0;
    b_if.region_begin = '0; b_if.data_load = '0; b_if.done = 1'b0;
    c_if.region_begin = '0; c_if.data_load = '0; c_if.done = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_a_req", {a_if.avail, a_if.r_en, a_if.w_en}, 0);
    chk("rst_d_req", {d_if.avail, d_if.r_en, d_if.w_en}, 0);
    chk("rst_a_ptr", a_if.ptr, 0);
    chk("rst_d_ptr", d_if.ptr, 0);
    chk("rst_d_store", d_if.data_store, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(vt[v], v, !vt[v].rnd);

    // Reset while the 10th element write is outstanding, then a clean recopy.
    load_vec(vt[0], 0);
    @(posedge clk);
    #1 go = 1'b1;
    cyc = 0;
    while (!(d_if.avail && d_if.ptr == D0 + 11) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_target_found", d_if.avail && d_if.ptr == D0 + 11, 1);
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    chk("midrst_reqs", {a_if.avail, a_if.r_en, d_if.avail, d_if.w_en}, 0);
    chk("midrst_done", done, 0);
    chk("midrst_d_ptr", d_if.ptr, 0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    run_vec(vt[0], 0, 1);

`ifdef FLATTEN_FW_CHECK_EN
    run_err(5, 1, 1, 1);
    run_err(2, 65536, 65536, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
